// File: rtl/input_debouncer_pkg.sv
// Shared defaults and helpers for the input debouncer.
package input_debouncer_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 12000;
    localparam int DEFAULT_N_INPUTS        = 5;

    // Width of a counter that must hold values 0 .. cycles-1.
    // Never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input bit.
// Path: two-flop synchroniser, stability counter, accepted level, and
// one-cycle rise/fall pulses.
module debounce_channel import input_debouncer_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = cnt_width(DEFAULT_DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic in_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    // The last count value before a new level is accepted.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s0_q, s0_d;
    logic             s1_q, s1_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state logic: shift the synchroniser, and count how long s1 has
    // disagreed with the accepted level.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through this block can infer a latch.
        s0_d    = in_raw;
        s1_d    = s0_q;
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s1_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                // The count is complete: accept the new value and pulse once.
                // The counter returns to zero here and never wraps.
                level_d = s1_q;
                rise_d  = s1_q;
                fall_d  = ~s1_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Any return of s1 to the level falls through to cnt_d = 0.
        // That discards a partial count without changing the outputs.
    end

    // State registers, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: every flop is reset, counter included, so a count in progress dies with no pulse.
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces N_INPUTS raw board pins, giving a level and rise/fall pulses
// per channel.
// Optional sticky event flags are enabled by defining
// INPUT_DEBOUNCER_STICKY_EN. That adds the events output and the ack input.
module input_debouncer import input_debouncer_pkg::*; #(
    parameter int N_INPUTS        = DEFAULT_N_INPUTS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_INPUTS-1:0] in_raw,
    output logic [N_INPUTS-1:0] level,
    output logic [N_INPUTS-1:0] rise,
    output logic [N_INPUTS-1:0] fall,
`ifdef INPUT_DEBOUNCER_STICKY_EN
    output logic [N_INPUTS-1:0] events,
    input  logic [N_INPUTS-1:0] ack,
`endif
    output logic                any_change
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .in_raw(in_raw[g]),
            .level (level[g]),
            .rise  (rise[g]),
            .fall  (fall[g])
        );
    end

    // rise and fall are already registered.
    // The OR therefore lands in the same cycle as the pulses.
    assign any_change = |(rise | fall);

`ifdef INPUT_DEBOUNCER_STICKY_EN
    logic [N_INPUTS-1:0] events_q, events_d;

    // Sticky flags: set by any pulse, cleared by ack.
    // A new event beats an ack in the same cycle.
    always_comb begin
        events_d = (events_q & ~ack) | rise | fall;
    end

    // Event flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            events_q <= '0;
        end else begin
            events_q <= events_d;
        end
    end

    assign events = events_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (DEBOUNCE_CYCLES=4, N_INPUTS=5).
module tb_input_debouncer;

    localparam int N    = 5;
    localparam int D    = 4;
    localparam int MAXC = 1024;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] in_raw = '0;
    logic [N-1:0] level, rise, fall;
    logic         any_change;
`ifdef INPUT_DEBOUNCER_STICKY_EN
    logic [N-1:0] events;
    logic [N-1:0] ack = '0;
    logic [N-1:0] ev_m = '0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    input_debouncer #(
        .N_INPUTS       (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_raw    (in_raw),
        .level     (level),
        .rise      (rise),
        .fall      (fall),
`ifdef INPUT_DEBOUNCER_STICKY_EN
        .events    (events),
        .ack       (ack),
`endif
        .any_change(any_change)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model keeps the full history of pin values and reset seen at each
    // edge.
    // A channel flips when the synchronised value has disagreed with the
    // level at each of the last D edges.
    // All of those edges must come after the channel's last change or reset.
    logic [N-1:0] raw_h [0:MAXC-1];
    bit           rst_h [0:MAXC-1];
    int           last_chg [N];
    int           k = 0;
    bit           model_valid = 0;
    logic [N-1:0] lvl_m = '0, rise_m = '0, fall_m = '0;

    // The synchronised value used at edge j.
    // It is the pin sampled two edges earlier, or 0 if reset cleared the
    // pipeline.
    function automatic logic s1_seen(input int j, input int i);
        if (j < 2) return 1'b0;
        if (rst_h[j-1] || rst_h[j-2]) return 1'b0;
        return raw_h[j-2][i];
    endfunction

    always @(posedge clk) begin
        if (k < MAXC) begin
            raw_h[k] = in_raw;
            rst_h[k] = rst;
            if (rst) begin
                model_valid = 1;
                lvl_m  = '0;
                rise_m = '0;
                fall_m = '0;
`ifdef INPUT_DEBOUNCER_STICKY_EN
                ev_m   = '0;
`endif
                for (int i = 0; i < N; i++) last_chg[i] = k;
            end else if (model_valid) begin
`ifdef INPUT_DEBOUNCER_STICKY_EN
                ev_m = (ev_m & ~ack) | rise_m | fall_m;
`endif
                for (int i = 0; i < N; i++) begin
                    bit stable;
                    stable = (k - D + 1) > last_chg[i];
                    for (int j = k - D + 1; j <= k; j++)
                        if (stable && s1_seen(j, i) == lvl_m[i]) stable = 0;
                    rise_m[i] = 1'b0;
                    fall_m[i] = 1'b0;
                    if (stable) begin
                        lvl_m[i]    = ~lvl_m[i];
                        rise_m[i]   = lvl_m[i];
                        fall_m[i]   = ~lvl_m[i];
                        last_chg[i] = k;
                    end
                end
            end
            k++;
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("level", 32'(level), 32'(lvl_m));
            check("rise", 32'(rise), 32'(rise_m));
            check("fall", 32'(fall), 32'(fall_m));
            check("any_change", 32'(any_change), 32'(|(rise_m | fall_m)));
            check("rise_fall_excl", 32'(rise & fall), 32'd0);
`ifdef INPUT_DEBOUNCER_STICKY_EN
            check("events", 32'(events), 32'(ev_m));
`endif
        end
    end

    // ---------------- directed stimulus with literal pins ----------------
    initial begin
        // Reset with all pins low, then stay quiet for 20 cycles.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_level", 32'(level), 32'd0);
            check("idle_any", 32'(any_change), 32'd0);
        end

        // Channel 0 rises.
        // The pin is first sampled at edge 0, and level follows at edge 5.
        in_raw[0] = 1'b1;
        for (int e = 0; e <= 4; e++) begin
            @(negedge clk);
            check("ch0_rise_early", 32'(rise), 32'd0);
        end
        @(negedge clk);
        check("ch0_level_e5", 32'(level), 32'h01);
        check("ch0_rise_e5", 32'(rise), 32'h01);
        check("ch0_any_e5", 32'(any_change), 32'd1);
        @(negedge clk);
        check("ch0_rise_e6", 32'(rise), 32'd0);
        check("ch0_any_e6", 32'(any_change), 32'd0);
`ifdef INPUT_DEBOUNCER_STICKY_EN
        check("ev0_set", 32'(events[0]), 32'd1);
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
        check("ev0_acked", 32'(events[0]), 32'd0);
`endif

        // Channel 2 glitch: high for 3 cycles only, so it must be rejected.
        in_raw[2] = 1'b1;
        repeat (3) @(negedge clk);
        in_raw[2] = 1'b0;
        repeat (10) @(negedge clk);
        check("ch2_glitch_level", 32'(level), 32'h01);

        // Channels 1 and 4 change together, so their pulses coincide.
        in_raw[1] = 1'b1;
        in_raw[4] = 1'b1;
        repeat (6) @(negedge clk);
        check("dual_rise", 32'(rise), 32'h12);
        @(negedge clk);
        check("dual_rise_off", 32'(rise), 32'd0);
        in_raw[1] = 1'b0;
        in_raw[4] = 1'b0;
        repeat (6) @(negedge clk);
        check("dual_fall", 32'(fall), 32'h12);
        check("dual_fall_level", 32'(level), 32'h01);
        repeat (2) @(negedge clk);

        // Channel 0 falls.
        // An ack in the same cycle as the fall pulse loses to the event.
        in_raw[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("ch0_fall", 32'(fall), 32'h01);
`ifdef INPUT_DEBOUNCER_STICKY_EN
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
        check("ev0_event_wins", 32'(events[0]), 32'd1);
`else
        @(negedge clk);
`endif

        // Channel 3 is held high through reset.
        // It rises 6 edges after the last reset edge.
        in_raw = 5'b01000;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_pulse", 32'(rise), 32'd0);
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            check("ch3_wait", 32'(rise), 32'd0);
        end
        @(negedge clk);
        check("ch3_rise", 32'(rise), 32'h08);

        // Second run: reset again, then reset once more mid-count.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midcount_rst_pulse", 32'(rise), 32'd0);
        check("midcount_rst_level", 32'(level), 32'd0);
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            check("ch3_wait2", 32'(rise), 32'd0);
        end
        @(negedge clk);
        check("ch3_rise2", 32'(rise), 32'h08);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
